// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the command payload.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS-phase wait-state watchdog: flags the cycle in which the
// TIMEOUT_CYC-th consecutive pready=0 wait is seen.
module apb_master_wdog #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic active_i,
  input  logic pready_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !pready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds waits already completed, so the limit is hit one below TIMEOUT_CYC.
  assign expire_c_o = active_i && !pready_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: single-outstanding command in, SETUP/ACCESS transfer out,
// one-cycle response strobe. Optional ACCESS timeout under APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYC must be within 1..65535");
  end

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              expire_c;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk       (pclk),
    .rst_n     (presetn),
    .start_i   (state_q == SETUP),
    .active_i  (state_q == ACCESS),
    .pready_i  (pready),
    .expire_c_o(expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Next-state and datapath decode; prdata/pslverr only matter on the completion edge.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (expire_c) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; the timeout section runs only when
// APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              pclk = 1'b0;
  logic              presetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(4)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic bus(input string tag, input logic s, input logic e, input logic rv);
    chk({tag, ".psel"}, 32'(psel), 32'(s));
    chk({tag, ".penable"}, 32'(penable), 32'(e));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step(); step();
    // reset state
    bus("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.paddr", paddr, 32'h0);
    chk("rst.pwdata", pwdata, 32'h0);
    chk("rst.pwrite", 32'(pwrite), 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(rsp_err), 32'h0);
    presetn = 1'b1;
    step();
    chk("rst.cmd_ready", 32'(cmd_ready), 32'h1);

    // write, zero wait
    cmd(1'b1, 32'h10, 32'hDEADBEEF); pready = 1'b1;
    step();
    bus("wr.setup", 1'b1, 1'b0, 1'b0);
    chk("wr.cmd_ready", 32'(cmd_ready), 32'h0);
    chk("wr.paddr", paddr, 32'h10);
    chk("wr.pwrite", 32'(pwrite), 32'h1);
    chk("wr.pwdata", pwdata, 32'hDEADBEEF);
    cmd_valid = 1'b0;
    step();
    bus("wr.access", 1'b1, 1'b1, 1'b0);
    step();
    bus("wr.rsp", 1'b0, 1'b0, 1'b1);
    chk("wr.rsp_err", 32'(rsp_err), 32'h0);
    chk("wr.rsp_rdata", rsp_rdata, 32'h0);
    chk("wr.cmd_ready", 32'(cmd_ready), 32'h1);
    chk("wr.idle_paddr", paddr, 32'h10);
    step();
    bus("wr.after", 1'b0, 1'b0, 1'b0);

    // read, 3 wait states; pwdata must not take cmd_wdata on a read
    cmd(1'b0, 32'h24, 32'hFFFF0000); pready = 1'b0; prdata = 32'hBAD0BAD0;
    step();
    bus("rd.setup", 1'b1, 1'b0, 1'b0);
    chk("rd.pwdata_kept", pwdata, 32'hDEADBEEF);
    chk("rd.pwrite", 32'(pwrite), 32'h0);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus($sformatf("rd.access%0d", k), 1'b1, 1'b1, 1'b0);
      chk($sformatf("rd.paddr%0d", k), paddr, 32'h24);
      if (k == 4) begin
        pready = 1'b1; prdata = 32'h12345678;
      end
    end
    step();
    bus("rd.rsp", 1'b0, 1'b0, 1'b1);
    chk("rd.rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd.rsp_err", 32'(rsp_err), 32'h0);

    // slave error with pready=1
    cmd(1'b0, 32'h30, 32'h0); pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
    step(); cmd_valid = 1'b0;
    step();
    step();
    bus("err.rsp", 1'b0, 1'b0, 1'b1);
    chk("err.rsp_err", 32'(rsp_err), 32'h1);
    chk("err.rsp_rdata", rsp_rdata, 32'hCAFEF00D);

    // pslverr while pready=0 is ignored
    cmd(1'b0, 32'h34, 32'h0); pready = 1'b0; pslverr = 1'b1;
    step(); cmd_valid = 1'b0;
    step();
    step();
    bus("ign.wait2", 1'b1, 1'b1, 1'b0);
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h55AA55AA;
    step();
    bus("ign.rsp", 1'b0, 1'b0, 1'b1);
    chk("ign.rsp_err", 32'(rsp_err), 32'h0);
    chk("ign.rsp_rdata", rsp_rdata, 32'h55AA55AA);

    // back-to-back reads with cmd_valid held
    pslverr = 1'b0;
    cmd(1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus($sformatf("b2b%0d.setup", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("b2b%0d.paddr", i), paddr, 32'h100 + 32'(4 * i));
      if (i == 2) cmd_valid = 1'b0;
      else cmd_addr = 32'h100 + 32'(4 * (i + 1));
      prdata = 32'hA0000000 + 32'(i);
      step();
      bus($sformatf("b2b%0d.access", i), 1'b1, 1'b1, 1'b0);
      chk($sformatf("b2b%0d.paddr_hold", i), paddr, 32'h100 + 32'(4 * i));
      step();
      bus($sformatf("b2b%0d.rsp", i), 1'b0, 1'b0, 1'b1);
      chk($sformatf("b2b%0d.rdata", i), rsp_rdata, 32'hA0000000 + 32'(i));
    end
    step();
    bus("b2b.end", 1'b0, 1'b0, 1'b0);

    // reset during ACCESS
    cmd(1'b0, 32'h40, 32'h0); pready = 1'b0;
    step(); cmd_valid = 1'b0;
    step();
    bus("rstmid.access", 1'b1, 1'b1, 1'b0);
    #2 presetn = 1'b0;
    #1;
    bus("rstmid.async", 1'b0, 1'b0, 1'b0);
    chk("rstmid.paddr", paddr, 32'h0);
    pready = 1'b1;
    step();
    presetn = 1'b1;
    chk("rstmid.cmd_ready", 32'(cmd_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      bus($sformatf("rstmid.quiet%0d", k), 1'b0, 1'b0, 1'b0);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // pready held low: abort after 4 ACCESS wait cycles
    cmd(1'b0, 32'h50, 32'h0); pready = 1'b0; prdata = 32'h99999999;
    step(); cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus($sformatf("to.access%0d", k), 1'b1, 1'b1, 1'b0);
    end
    step();
    bus("to.rsp", 1'b0, 1'b0, 1'b1);
    chk("to.rsp_err", 32'(rsp_err), 32'h1);
    chk("to.rsp_rdata", rsp_rdata, 32'h0);
    step();
    // pready on the 4th ACCESS cycle wins over the timeout
    cmd(1'b0, 32'h54, 32'h0); pready = 1'b0;
    step(); cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus($sformatf("tok.access%0d", k), 1'b1, 1'b1, 1'b0);
      if (k == 4) begin
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h00000077;
      end
    end
    step();
    bus("tok.rsp", 1'b0, 1'b0, 1'b1);
    chk("tok.rsp_err", 32'(rsp_err), 32'h0);
    chk("tok.rsp_rdata", rsp_rdata, 32'h00000077);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
